// File: rtl/counter_mod_n_updn.sv
// Modulo-MOD up/down counter with clear, checked parallel load, wrap/saturate
// modes, a combinational cascade carry and registered wrap/load-error pulses.
module counter_mod_n_updn #(
    parameter int MOD   = 100,
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             sat,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ld_err
);

    localparam logic [WIDTH-1:0] TOP  = WIDTH'(MOD - 1);
    localparam logic [WIDTH:0]   MODX = (WIDTH + 1)'(MOD);

    generate
        if (MOD < 2 || MOD > (1 << WIDTH)) begin : g_bad_param
            $error("counter_mod_n_updn: MOD must lie in 2..2**WIDTH");
        end
    endgenerate

    logic             at_top;
    logic             at_bot;
    logic             ld_ok;
    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;
    logic             ld_err_nxt;

    assign at_top = (count == TOP);
    assign at_bot = (count == '0);
    // One extra bit so MOD == 2**WIDTH accepts every load value.
    assign ld_ok  = ({1'b0, ld_val} < MODX);

    assign tc = ~rst & en & ((up & at_top) | (~up & at_bot));

    always_comb begin
        count_nxt  = count;
        wrap_nxt   = 1'b0;
        ld_err_nxt = 1'b0;
        if (clr) begin
            count_nxt = '0;
        end else if (ld) begin
            if (ld_ok) begin
                count_nxt = ld_val;
            end else begin
                ld_err_nxt = 1'b1;
            end
        end else if (en) begin
            if (up) begin
                if (!at_top) begin
                    count_nxt = count + WIDTH'(1);
                end else if (!sat) begin
                    count_nxt = '0;
                    wrap_nxt  = 1'b1;
                end
            end else begin
                if (!at_bot) begin
                    count_nxt = count - WIDTH'(1);
                end else if (!sat) begin
                    count_nxt = TOP;
                    wrap_nxt  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            wrap   <= 1'b0;
            ld_err <= 1'b0;
        end else begin
            count  <= count_nxt;
            wrap   <= wrap_nxt;
            ld_err <= ld_err_nxt;
        end
    end

endmodule

// File: tb/tb_counter_mod_n_updn.sv
// Randomised and directed bench for counter_mod_n_updn: mod-100 unit,
// a two-digit mod-10 cascade and a mod-2 unit.
module tb_counter_mod_n_updn;

    localparam int M = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main mod-100 instance
    logic       rst, en, up, clr, ld, sat;
    logic [6:0] ld_val;
    logic [6:0] count;
    logic       tc, wrap, ld_err;

    counter_mod_n_updn #(.MOD(100), .WIDTH(7)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .ld(ld),
        .ld_val(ld_val), .sat(sat), .count(count), .tc(tc), .wrap(wrap),
        .ld_err(ld_err)
    );

    // Two-digit decimal cascade
    logic       c_rst, c_en;
    logic [3:0] lo_cnt, hi_cnt;
    logic       lo_tc, hi_tc, lo_wrap, hi_wrap, lo_err, hi_err;

    counter_mod_n_updn #(.MOD(10), .WIDTH(4)) u_lo (
        .clk(clk), .rst(c_rst), .en(c_en), .up(1'b1), .clr(1'b0),
        .ld(1'b0), .ld_val(4'd0), .sat(1'b0), .count(lo_cnt), .tc(lo_tc),
        .wrap(lo_wrap), .ld_err(lo_err)
    );

    counter_mod_n_updn #(.MOD(10), .WIDTH(4)) u_hi (
        .clk(clk), .rst(c_rst), .en(lo_tc), .up(1'b1), .clr(1'b0),
        .ld(1'b0), .ld_val(4'd0), .sat(1'b0), .count(hi_cnt), .tc(hi_tc),
        .wrap(hi_wrap), .ld_err(hi_err)
    );

    // Mod-2 instance
    logic d_rst, d_up;
    logic d_cnt;
    logic d_tc, d_wrap, d_err;

    counter_mod_n_updn #(.MOD(2), .WIDTH(1)) u_d2 (
        .clk(clk), .rst(d_rst), .en(1'b1), .up(d_up), .clr(1'b0),
        .ld(1'b0), .ld_val(1'b0), .sat(1'b0), .count(d_cnt), .tc(d_tc),
        .wrap(d_wrap), .ld_err(d_err)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model of the mod-100 instance
    int m_cnt   = 0;
    bit m_wrap  = 1'b0;
    bit m_lderr = 1'b0;

    function automatic void model_edge();
        if (rst) begin
            m_cnt = 0; m_wrap = 0; m_lderr = 0;
        end else if (clr) begin
            m_cnt = 0; m_wrap = 0; m_lderr = 0;
        end else if (ld) begin
            m_wrap = 0;
            if (int'(ld_val) < M) begin
                m_cnt = int'(ld_val); m_lderr = 0;
            end else begin
                m_lderr = 1;
            end
        end else if (en) begin
            m_lderr = 0;
            if (!sat) begin
                m_wrap = up ? (m_cnt == M - 1) : (m_cnt == 0);
                m_cnt  = (m_cnt + (up ? 1 : M - 1)) % M;
            end else begin
                m_wrap = 0;
                if (up && m_cnt < M - 1) m_cnt = m_cnt + 1;
                else if (!up && m_cnt > 0) m_cnt = m_cnt - 1;
            end
        end else begin
            m_wrap = 0; m_lderr = 0;
        end
    endfunction

    function automatic bit exp_tc();
        return !rst && en && (up ? (m_cnt == M - 1) : (m_cnt == 0));
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit r, input bit e, input bit u,
                          input bit c, input bit l, input int v, input bit s);
        rst = r; en = e; up = u; clr = c; ld = l; ld_val = 7'(v); sat = s;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(1, $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 127), $urandom_range(0, 1));
            #1;
            checks++;
            if (tc !== 1'b0) begin
                errors++;
                $display("FAIL reset_tc: got %b want 0", tc);
            end
            tick();
            checks++;
            if (count !== 7'd0 || wrap !== 1'b0 || ld_err !== 1'b0) begin
                errors++;
                $display("FAIL reset_state: got cnt=%0d wrap=%b err=%b want 0/0/0",
                         count, wrap, ld_err);
            end
        end
    endtask

    task automatic test_wrap_up();
        int nwrap = 0;
        set_in(1, 1, 1, 0, 0, 0, 0);
        tick();
        rst = 0;
        for (int i = 1; i <= 250; i++) begin
            #1;
            checks++;
            if (tc !== exp_tc() || tc !== (((i - 1) % M) == M - 1)) begin
                errors++;
                $display("FAIL up_tc[%0d]: got %b want %b", i, tc, exp_tc());
            end
            tick();
            checks++;
            if (int'(count) != i % M || wrap !== (i % M == 0) || ld_err !== 0) begin
                errors++;
                $display("FAIL up_count[%0d]: got cnt=%0d wrap=%b want cnt=%0d wrap=%b",
                         i, count, wrap, i % M, i % M == 0);
            end
            if (wrap) nwrap++;
        end
        checks++;
        if (nwrap != 2) begin
            errors++;
            $display("FAIL up_wrap_total: got %0d want 2", nwrap);
        end
    endtask

    task automatic test_down_sat();
        set_in(0, 0, 0, 1, 0, 0, 0);
        tick();
        set_in(0, 1, 0, 0, 0, 0, 0);
        tick();
        checks++;
        if (count !== 7'd99 || wrap !== 1'b1) begin
            errors++;
            $display("FAIL down_wrap: got cnt=%0d wrap=%b want 99/1", count, wrap);
        end
        set_in(0, 0, 0, 1, 0, 0, 0);
        tick();
        set_in(0, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (tc !== 1'b1) begin
                errors++;
                $display("FAIL sat_tc[%0d]: got %b want 1", i, tc);
            end
            tick();
            checks++;
            if (count !== 7'd0 || wrap !== 1'b0) begin
                errors++;
                $display("FAIL sat_hold[%0d]: got cnt=%0d wrap=%b want 0/0",
                         i, count, wrap);
            end
        end
    endtask

    task automatic test_load();
        set_in(0, 1, 1, 0, 1, 42, 0);
        tick();
        checks++;
        if (count !== 7'd42 || ld_err !== 1'b0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL load_ok: got cnt=%0d err=%b want 42/0", count, ld_err);
        end
        set_in(0, 1, 1, 0, 1, 100, 0);
        tick();
        checks++;
        if (count !== 7'd42 || ld_err !== 1'b1) begin
            errors++;
            $display("FAIL load_bad: got cnt=%0d err=%b want 42/1", count, ld_err);
        end
        set_in(0, 0, 1, 0, 0, 0, 0);
        tick();
        checks++;
        if (count !== 7'd42 || ld_err !== 1'b0) begin
            errors++;
            $display("FAIL load_pulse: got cnt=%0d err=%b want 42/0", count, ld_err);
        end
        set_in(0, 1, 1, 1, 1, 5, 0);
        tick();
        checks++;
        if (count !== 7'd0 || ld_err !== 1'b0) begin
            errors++;
            $display("FAIL load_clr: got cnt=%0d err=%b want 0/0", count, ld_err);
        end
    endtask

    task automatic test_reset_mid();
        set_in(0, 0, 1, 0, 1, 57, 0);
        tick();
        set_in(0, 0, 1, 0, 1, 127, 0);
        tick();
        checks++;
        if (count !== 7'd57 || ld_err !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup: got cnt=%0d err=%b want 57/1", count, ld_err);
        end
        set_in(1, 1, 1, 0, 1, 120, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (tc !== 1'b0) begin
                errors++;
                $display("FAIL mid_rst_tc[%0d]: got %b want 0", i, tc);
            end
            tick();
            checks++;
            if (count !== 7'd0 || wrap !== 1'b0 || ld_err !== 1'b0) begin
                errors++;
                $display("FAIL mid_rst[%0d]: got cnt=%0d wrap=%b err=%b want 0/0/0",
                         i, count, wrap, ld_err);
            end
        end
        set_in(0, 1, 1, 0, 0, 0, 0);
        tick();
        checks++;
        if (count !== 7'd1) begin
            errors++;
            $display("FAIL mid_resume: got cnt=%0d want 1", count);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            set_in($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                   $urandom_range(0, 1), $urandom_range(0, 29) == 0,
                   $urandom_range(0, 9) == 0, $urandom_range(0, 127),
                   $urandom_range(0, 3) == 0);
            #1;
            checks++;
            if (tc !== exp_tc()) begin
                errors++;
                $display("FAIL rand_tc[%0d]: got %b want %b", i, tc, exp_tc());
            end
            tick();
            checks++;
            if (int'(count) != m_cnt || wrap !== m_wrap || ld_err !== m_lderr) begin
                errors++;
                $display("FAIL rand[%0d]: got cnt=%0d wrap=%b err=%b want %0d/%b/%b",
                         i, count, wrap, ld_err, m_cnt, m_wrap, m_lderr);
            end
        end
    endtask

    task automatic test_cascade();
        c_rst = 1; c_en = 1;
        tick();
        c_rst = 0;
        for (int i = 1; i <= 99; i++) begin
            tick();
            checks++;
            if (int'(lo_cnt) != i % 10 || int'(hi_cnt) != i / 10) begin
                errors++;
                $display("FAIL casc[%0d]: got %0d%0d want %0d", i, hi_cnt, lo_cnt, i);
            end
        end
        tick();
        checks++;
        if (lo_cnt !== 4'd0 || hi_cnt !== 4'd0 || lo_wrap !== 1'b1 || hi_wrap !== 1'b1) begin
            errors++;
            $display("FAIL casc_wrap: got %0d%0d wraps=%b%b want 00 wraps=11",
                     hi_cnt, lo_cnt, hi_wrap, lo_wrap);
        end
        c_en = 0;
    endtask

    task automatic test_mod2();
        int prev;
        bit exp_w;
        d_rst = 1; d_up = 1;
        tick();
        d_rst = 0;
        prev = 0;
        for (int i = 0; i < 40; i++) begin
            if (i >= 20) d_up = 1'($urandom_range(0, 1));
            exp_w = d_up ? (prev == 1) : (prev == 0);
            tick();
            prev = 1 - prev;
            checks++;
            if (int'(d_cnt) != prev || d_wrap !== exp_w) begin
                errors++;
                $display("FAIL mod2[%0d]: got cnt=%0d wrap=%b want %0d/%b",
                         i, d_cnt, d_wrap, prev, exp_w);
            end
        end
    endtask

    initial begin
        set_in(1, 0, 1, 0, 0, 0, 0);
        c_rst = 1; c_en = 0;
        d_rst = 1; d_up = 1;
        @(posedge clk);
        #1;
        test_reset();
        test_wrap_up();
        test_down_sat();
        test_load();
        test_reset_mid();
        test_random();
        test_cascade();
        test_mod2();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
